rd_sel_pipe: RTL

RD_SEL_PIPE -- requirements
Module: rd_sel_pipe

---
 rtl/rd_sel_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/rd_sel_pipe.sv
// Per-port bank-read return pipeline: delays {valid, sel} by READ_LATENCY cycles,
// routes the selected bank's read data back to each port and tracks in-flight reads.
module rd_sel_pipe #(
    parameter int NUM_PORTS    = 2,
    parameter int NUM_BANKS    = 4,
    parameter int SEL_W        = $clog2(NUM_BANKS),
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int CNT_W        = $clog2(READ_LATENCY + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            i_rd_en,
    input  logic [NUM_PORTS*SEL_W-1:0]      i_bank_sel,
    input  logic                            i_flush,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_PORTS-1:0]            o_rd_valid,
    output logic [NUM_PORTS*SEL_W-1:0]      o_bank_sel_d,
    output logic [NUM_PORTS*CNT_W-1:0]      o_outstanding,
    output logic [NUM_PORTS-1:0]            o_sel_err
);

    // Every select code addresses a real bank, so an out-of-range request cannot occur.
    localparam bit SEL_FULL = (NUM_BANKS == (1 << SEL_W));

    logic [READ_LATENCY-1:0] vld_q  [NUM_PORTS];
    logic [SEL_W-1:0]        sel_q  [NUM_PORTS][READ_LATENCY];
    logic [CNT_W-1:0]        cnt_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0]    err_q;

    logic [SEL_W-1:0]        sel_in [NUM_PORTS];
    logic [NUM_PORTS-1:0]    in_range;
    logic [NUM_PORTS-1:0]    accept;
    logic [NUM_PORTS-1:0]    bad_sel;

    always_comb begin
        in_range = '0;
        accept   = '0;
        bad_sel  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel_in[p]   = i_bank_sel[p*SEL_W +: SEL_W];
            in_range[p] = (32'(sel_in[p]) < 32'(NUM_BANKS));
            accept[p]   = i_rd_en[p] & ~i_flush & in_range[p];
            bad_sel[p]  = i_rd_en[p] & ~i_flush & ~in_range[p];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                vld_q[p] <= '0;
                cnt_q[p] <= '0;
                for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                    sel_q[p][s] <= '0;
                end
            end
        end else begin
            err_q <= bad_sel & ~{NUM_PORTS{SEL_FULL}};
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                // Select fields keep shifting through a flush; only the valids are dropped.
                sel_q[p][0] <= sel_in[p];
                for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                    sel_q[p][s] <= sel_q[p][s-1];
                end
                if (i_flush) begin
                    vld_q[p] <= '0;
                    cnt_q[p] <= '0;
                end else begin
                    vld_q[p][0] <= accept[p];
                    for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                        vld_q[p][s] <= vld_q[p][s-1];
                    end
                    if (accept[p] && !vld_q[p][READ_LATENCY-1]) begin
                        cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                    end else if (!accept[p] && vld_q[p][READ_LATENCY-1]) begin
                        cnt_q[p] <= cnt_q[p] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_data     = '0;
        o_rd_valid    = '0;
        o_bank_sel_d  = '0;
        o_outstanding = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            o_rd_valid[p]                     = vld_q[p][READ_LATENCY-1];
            o_bank_sel_d[p*SEL_W +: SEL_W]    = sel_q[p][READ_LATENCY-1];
            o_outstanding[p*CNT_W +: CNT_W]   = cnt_q[p];
            if (vld_q[p][READ_LATENCY-1]) begin
                o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
                    i_bank_rdata[32'(sel_q[p][READ_LATENCY-1])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_sel_err = err_q;

endmodule
